// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder.
//   - Include-guarded `define block: FSM state encodings and the nibble width.
//   - nibble_serial_adder_pkg: typed state enum, nibble width localparam and the
//     signed-overflow helper used when the last nibble retires.
// This file must be compiled before the other nibble_serial_adder sources.

`ifndef NIBBLE_SERIAL_ADDER_DEFS
`define NIBBLE_SERIAL_ADDER_DEFS
`define ST_IDLE 2'd0
`define ST_RUN 2'd1
`define ST_DONE 2'd2
`define NIB_BITS 4
`endif

package nibble_serial_adder_pkg;

  typedef enum logic [1:0] {
    StIdle = `ST_IDLE,
    StRun  = `ST_RUN,
    StDone = `ST_DONE
  } state_e;

  localparam int unsigned NibBits = `NIB_BITS;

  // Two's-complement overflow: operands share a sign and the result sign differs.
  function automatic logic signed_ovf(logic a_msb, logic b_msb, logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/cla_adder_4bit.sv
// 4-bit carry-lookahead adder slice.
// Ports:
//   a, b   : 4-bit addends
//   c_in   : carry into bit 0
//   s      : 4-bit sum
//   c_out  : carry out of bit 3

module cla_adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       c_out
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  always_comb begin
    g = a & b;
    p = a ^ b;
    // Every carry is a flat function of g/p/c_in; no rippling between bits.
    c[0] = c_in;
    c[1] = g[0] | (p[0] & c_in);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c_in);
    s     = p ^ c[3:0];
    c_out = c[4];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor built around one shared 4-bit CLA slice.
// One nibble is processed per clock, LSB first, with the carry held in a flop.
// Ports:
//   clk, rst            : clock (rising edge), synchronous active-high reset
//   in_valid, in_ready  : operand handshake; in_ready is high only when idle
//   a, b, c_in, sub     : operands; sub=1 computes a - b and ignores c_in
//   out_valid, out_ready: result handshake; out_valid is high only in DONE
//   s, c_out, overflow  : result, final carry (sub: 1 = no borrow), signed overflow

module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             overflow
);

  localparam int unsigned NIB  = WIDTH / NibBits;
  localparam int unsigned CntW = $clog2(NIB);
  localparam logic [CntW-1:0] LastStep = CntW'(NIB - 1);

  state_e            state_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;      // already inverted for subtraction
  logic              carry_q;
  logic [CntW-1:0]   cnt_q;
  logic [WIDTH-1:0]  sum_q;
  logic              a_msb_q;
  logic              b_msb_q;
  logic              ovf_q;

  logic [3:0] slice_s;
  logic       slice_c;

  // The slice always looks at the low nibble; operands shift down each step.
  cla_adder_4bit u_slice (
    .a     (a_q[3:0]),
    .b     (b_q[3:0]),
    .c_in  (carry_q),
    .s     (slice_s),
    .c_out (slice_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : c_in;
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
            cnt_q   <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          sum_q[{cnt_q, 2'b00} +: 4] <= slice_s;
          carry_q <= slice_c;
          a_q     <= a_q >> NibBits;
          b_q     <= b_q >> NibBits;
          if (cnt_q == LastStep) begin
            // slice_s[3] is the result MSB on the final step.
            ovf_q   <= signed_ovf(a_msb_q, b_msb_q, slice_s[3]);
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign s         = sum_q;
  assign c_out     = carry_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        c_in;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] s;
  logic        c_out;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  nibble_serial_adder #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .c_out     (c_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [31:0] va;
    logic [31:0] vb;
    logic        vci;
    logic        vsub;
    logic [31:0] es;
    logic        ec;
    logic        eo;
    int          hold;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands' values.
  task automatic model(input logic [31:0] ma, input logic [31:0] mb, input logic mci,
                       input logic msub, output logic [31:0] rs, output logic rc,
                       output logic ro);
    longint sr;
    logic [32:0] full;
    if (msub) begin
      rs = ma - mb;
      rc = (ma >= mb);
      sr = longint'($signed(ma)) - longint'($signed(mb));
    end else begin
      full = {1'b0, ma} + {1'b0, mb} + {32'd0, mci};
      rs = full[31:0];
      rc = full[32];
      sr = longint'($signed(ma)) + longint'($signed(mb)) + longint'(mci);
    end
    ro = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
  endtask

  // One full transaction; operand inputs carry junk with in_valid=1 while busy.
  task automatic run_op(input string nm, input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic tci, input logic tsub, input logic [31:0] es,
                        input logic ec, input logic eo, input int hold);
    int lat;
    @(negedge clk);
    check({nm, ".in_ready_idle"}, 64'(in_ready), 64'd1);
    a = ta; b = tb_v; c_in = tci; sub = tsub; in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    a = $urandom; b = $urandom; c_in = 1'($urandom); sub = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (!out_valid) begin
        a = $urandom; b = $urandom;
      end
    end
    check({nm, ".latency"}, 64'(lat), 64'd8);
    check({nm, ".s"}, 64'(s), 64'(es));
    check({nm, ".c_out"}, 64'(c_out), 64'(ec));
    check({nm, ".overflow"}, 64'(overflow), 64'(eo));
    check({nm, ".in_ready_done"}, 64'(in_ready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({nm, ".hold_valid"}, 64'(out_valid), 64'd1);
      check({nm, ".hold_s"}, 64'(s), 64'(es));
      check({nm, ".hold_in_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({nm, ".retired"}, 64'(out_valid), 64'd0);
    check({nm, ".in_ready_after"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb, rs;
    logic        rci, rsub, rc, ro;
    logic        seen;
    logic [31:0] edge_vals[4];

    vecs[0] = '{"carry_chain", 32'h0000000F, 32'h00000001, 1'b0, 1'b0, 32'h00000010, 1'b0, 1'b0, 0};
    vecs[1] = '{"full_wrap",   32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 0};
    vecs[2] = '{"sub_neg",     32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1};
    vecs[3] = '{"sub_ovf",     32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 0};
    vecs[4] = '{"add_ovf",     32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 2};
    vecs[5] = '{"backpress",   32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 32'hACF13568, 1'b0, 1'b0, 5};
    vecs[6] = '{"sub_cin_ign", 32'h00000005, 32'h00000005, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0, 0};
    vecs[7] = '{"add_cin",     32'h00000001, 32'h00000001, 1'b1, 1'b0, 32'h00000003, 1'b0, 1'b0, 0};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset.in_ready", 64'(in_ready), 64'd1);
    check("reset.out_valid", 64'(out_valid), 64'd0);
    check("reset.s", 64'(s), 64'd0);
    check("reset.c_out", 64'(c_out), 64'd0);
    check("reset.overflow", 64'(overflow), 64'd0);

    foreach (vecs[i]) begin
      run_op(vecs[i].nm, vecs[i].va, vecs[i].vb, vecs[i].vci, vecs[i].vsub,
             vecs[i].es, vecs[i].ec, vecs[i].eo, vecs[i].hold);
    end

    // Reset after nibble step 3 of a run: operation must vanish without a result.
    @(negedge clk);
    a = 32'hDEADBEEF; b = 32'h11111111; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort.in_ready", 64'(in_ready), 64'd1);
    check("abort.out_valid", 64'(out_valid), 64'd0);
    check("abort.s", 64'(s), 64'd0);
    check("abort.c_out", 64'(c_out), 64'd0);
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("abort.no_result", 64'(seen), 64'd0);
    run_op("after_abort", 32'd1, 32'd1, 1'b0, 1'b0, 32'd2, 1'b0, 1'b0, 0);

    edge_vals[0] = 32'h00000000;
    edge_vals[1] = 32'hFFFFFFFF;
    edge_vals[2] = 32'h7FFFFFFF;
    edge_vals[3] = 32'h80000000;
    for (int n = 0; n < 40; n++) begin
      ra = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
      rci = 1'($urandom);
      rsub = 1'($urandom);
      model(ra, rb, rci, rsub, rs, rc, ro);
      run_op("random", ra, rb, rci, rsub, rs, rc, ro, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
